// File: rtl/writeback_stage_if.sv
// Memory-stage to writeback-stage bus: retiring instruction, pipeline control and register-file write port.
interface writeback_stage_if;
    logic        Stall;
    logic        Flush;
    logic        MemValid;
    logic        MemRegWrite;
    logic        MemToReg;
    logic [2:0]  MemLoadType;
    logic [1:0]  MemAddrLow;
    logic [31:0] MemReadData;
    logic [31:0] MemAluResult;
    logic [4:0]  MemWriteRegister;
    logic        RegWrite;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        WbValid;
    logic [31:0] RetireCount;
    logic        Trap;

    modport master (
        output Stall, Flush, MemValid, MemRegWrite, MemToReg, MemLoadType,
               MemAddrLow, MemReadData, MemAluResult, MemWriteRegister,
        input  RegWrite, WriteRegister, WriteData, WbValid, RetireCount, Trap
    );

    modport slave (
        input  Stall, Flush, MemValid, MemRegWrite, MemToReg, MemLoadType,
               MemAddrLow, MemReadData, MemAluResult, MemWriteRegister,
        output RegWrite, WriteRegister, WriteData, WbValid, RetireCount, Trap
    );
endinterface

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with sub-word load formatting, $zero suppression and retire counter.
// Optional sticky misaligned-load trap enabled by defining WB_MISALIGN_TRAP_EN.
module writeback_stage #(
    parameter logic [31:0] RESET_PC_COUNT = 32'd0
) (
    input logic              Clock,
    input logic              Reset_n,
    writeback_stage_if.slave bus
);
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    typedef enum logic [2:0] {
        LD_LW  = 3'd0,
        LD_LH  = 3'd1,
        LD_LHU = 3'd2,
        LD_LB  = 3'd3,
        LD_LBU = 3'd4
    } load_e;

    logic          valid_q, valid_d;
    logic          reg_write_q, reg_write_d;
    logic [RW-1:0] write_reg_q, write_reg_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic [DW-1:0] retire_cnt_q, retire_cnt_d;

    logic [15:0]   half_c;
    logic [7:0]    byte_c;
    logic [DW-1:0] load_data_c;
    logic          trap_hit_c;

    // Big-endian lane select: lower address picks the more significant lane.
    always_comb begin
        half_c = bus.MemAddrLow[1] ? bus.MemReadData[15:0] : bus.MemReadData[31:16];
        case (bus.MemAddrLow)
            2'd0:    byte_c = bus.MemReadData[31:24];
            2'd1:    byte_c = bus.MemReadData[23:16];
            2'd2:    byte_c = bus.MemReadData[15:8];
            default: byte_c = bus.MemReadData[7:0];
        endcase
        case (bus.MemLoadType)
            LD_LH:   load_data_c = {{16{half_c[15]}}, half_c};
            LD_LHU:  load_data_c = {16'h0000, half_c};
            LD_LB:   load_data_c = {{24{byte_c[7]}}, byte_c};
            LD_LBU:  load_data_c = {24'h000000, byte_c};
            default: load_data_c = bus.MemReadData;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    logic trap_q, trap_d;
    logic misaligned_c;

    always_comb begin
        case (bus.MemLoadType)
            LD_LH, LD_LHU: misaligned_c = bus.MemAddrLow[0];
            LD_LB, LD_LBU: misaligned_c = 1'b0;
            default:       misaligned_c = (bus.MemAddrLow != 2'd0);
        endcase
        trap_hit_c = bus.MemToReg & misaligned_c;
    end
`else
    assign trap_hit_c = 1'b0;
`endif

    // Next-state: capture when not stalled, otherwise hold everything.
    always_comb begin
        valid_d      = valid_q;
        reg_write_d  = reg_write_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        retire_cnt_d = retire_cnt_q;
`ifdef WB_MISALIGN_TRAP_EN
        trap_d       = trap_q;
`endif
        if (!bus.Stall) begin
            valid_d      = bus.MemValid & ~bus.Flush;
            reg_write_d  = bus.MemValid & ~bus.Flush & bus.MemRegWrite
                         & (bus.MemWriteRegister != RW'(0)) & ~trap_hit_c;
            write_reg_d  = bus.MemWriteRegister;
            write_data_d = bus.MemToReg ? load_data_c : bus.MemAluResult;
            retire_cnt_d = retire_cnt_q + DW'(valid_q);
`ifdef WB_MISALIGN_TRAP_EN
            trap_d       = trap_q | (bus.MemValid & ~bus.Flush & trap_hit_c);
`endif
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            retire_cnt_q <= RESET_PC_COUNT;
`ifdef WB_MISALIGN_TRAP_EN
            trap_q       <= 1'b0;
`endif
        end else begin
            valid_q      <= valid_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            retire_cnt_q <= retire_cnt_d;
`ifdef WB_MISALIGN_TRAP_EN
            trap_q       <= trap_d;
`endif
        end
    end

    assign bus.WbValid       = valid_q;
    assign bus.RegWrite      = reg_write_q;
    assign bus.WriteRegister = write_reg_q;
    assign bus.WriteData     = write_data_q;
    assign bus.RetireCount   = retire_cnt_q;
`ifdef WB_MISALIGN_TRAP_EN
    assign bus.Trap          = trap_q;
`else
    assign bus.Trap          = 1'b0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_writeback_stage;
`ifdef WB_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam logic [31:0] WRAP_BASE = 32'hFFFF_FFFE;

    logic Clock;
    logic Reset_n;
    int   errs;
    int   checks;

    writeback_stage_if mif ();
    writeback_stage_if wif ();

    writeback_stage #(.RESET_PC_COUNT(32'd0)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .bus(mif.slave));
    writeback_stage #(.RESET_PC_COUNT(WRAP_BASE)) dut_wrap (
        .Clock(Clock), .Reset_n(Reset_n), .bus(wif.slave));

    // Second instance sees identical stimulus; only its counter base differs.
    assign wif.Stall            = mif.Stall;
    assign wif.Flush            = mif.Flush;
    assign wif.MemValid         = mif.MemValid;
    assign wif.MemRegWrite      = mif.MemRegWrite;
    assign wif.MemToReg         = mif.MemToReg;
    assign wif.MemLoadType      = mif.MemLoadType;
    assign wif.MemAddrLow       = mif.MemAddrLow;
    assign wif.MemReadData      = mif.MemReadData;
    assign wif.MemAluResult     = mif.MemAluResult;
    assign wif.MemWriteRegister = mif.MemWriteRegister;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model state
    logic        m_valid, m_rw, m_trap, m_wd_known;
    logic [4:0]  m_wr;
    logic [31:0] m_wd, m_cnt;

    function automatic logic [31:0] fmt(input logic to_reg, input int lt, input int addr,
                                        input logic [31:0] rd, input logic [31:0] alu);
        logic [31:0] v;
        if (!to_reg) return alu;
        case (lt)
            1, 2: begin
                v = (addr >= 2) ? (rd % 65536) : (rd / 65536);
                if (lt == 1 && v >= 32768) v = v + 32'hFFFF_0000;
            end
            3, 4: begin
                v = (rd >> (8 * (3 - addr))) % 256;
                if (lt == 3 && v >= 128) v = v + 32'hFFFF_FF00;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic misaligned(input logic to_reg, input int lt, input int addr);
        if (!to_reg) return 1'b0;
        if (lt == 1 || lt == 2) return (addr % 2) == 1;
        if (lt == 3 || lt == 4) return 1'b0;
        return addr != 0;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_trap = 0; m_wr = 0; m_wd = 0; m_cnt = 0; m_wd_known = 1;
    endtask

    task automatic model_edge();
        logic mis;
        if (mif.Stall) return;
        if (m_valid) m_cnt = m_cnt + 1;
        mis        = TRAP_EN && misaligned(mif.MemToReg, int'(mif.MemLoadType), int'(mif.MemAddrLow));
        m_valid    = mif.MemValid && !mif.Flush;
        m_rw       = m_valid && mif.MemRegWrite && (mif.MemWriteRegister != 0) && !mis;
        m_trap     = m_trap || (m_valid && mis);
        m_wr       = mif.MemWriteRegister;
        m_wd       = fmt(mif.MemToReg, int'(mif.MemLoadType), int'(mif.MemAddrLow),
                         mif.MemReadData, mif.MemAluResult);
        m_wd_known = !mif.Flush;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic tr, input logic [2:0] lt,
                         input logic [1:0] al, input logic [31:0] rd, input logic [31:0] alu,
                         input logic [4:0] wr);
        mif.MemValid = v; mif.MemRegWrite = rw; mif.MemToReg = tr; mif.MemLoadType = lt;
        mif.MemAddrLow = al; mif.MemReadData = rd; mif.MemAluResult = alu; mif.MemWriteRegister = wr;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        mif.Stall = 1'b1; mif.Flush = 1'b1;
        drive(1, 1, 1, 3'd3, 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
        @(posedge Clock); #1;
        mif.Stall = 1'b0; mif.Flush = 1'b0;
        @(posedge Clock); #1;
        checks++;
        if ({mif.RegWrite, mif.WbValid, mif.Trap} !== 3'b000 || mif.WriteRegister !== 5'd0
            || mif.WriteData !== 32'd0) begin
            errs++;
            $display("FAIL reset_outputs: rw=%b v=%b trap=%b wr=%0d wd=%h, required all zero",
                     mif.RegWrite, mif.WbValid, mif.Trap, mif.WriteRegister, mif.WriteData);
        end
        checks++;
        if (mif.RetireCount !== 32'd0 || wif.RetireCount !== WRAP_BASE) begin
            errs++;
            $display("FAIL reset_count: got %h/%h, required 00000000/%h",
                     mif.RetireCount, wif.RetireCount, WRAP_BASE);
        end
        Reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_alu();
        drive(1, 1, 0, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h1234_5678, 5'd5);
        tick();
        checks++;
        if (mif.RegWrite !== 1'b1 || mif.WriteRegister !== 5'd5 || mif.WriteData !== 32'h1234_5678
            || mif.WbValid !== 1'b1 || mif.RetireCount !== 32'd0) begin
            errs++;
            $display("FAIL alu_capture: rw=%b wr=%0d wd=%h v=%b cnt=%0d, required 1/5/12345678/1/0",
                     mif.RegWrite, mif.WriteRegister, mif.WriteData, mif.WbValid, mif.RetireCount);
        end
        drive(0, 0, 0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd0);
        tick();
        checks++;
        if (mif.RetireCount !== 32'd1 || mif.WbValid !== 1'b0) begin
            errs++;
            $display("FAIL alu_retire: cnt=%0d v=%b, required 1/0", mif.RetireCount, mif.WbValid);
        end
    endtask

    task automatic test_format();
        logic [2:0]  lts [5] = '{3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
        logic [1:0]  ads [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_00F1, 32'h0000_7F01, 32'h0000_80F1, 32'h80F1_7F01};
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 1, lts[i], ads[i], 32'h80F1_7F01, 32'h5555_AAAA, 5'd9);
            tick();
            checks++;
            if (mif.WriteData !== exp[i] || mif.RegWrite !== 1'b1) begin
                errs++;
                $display("FAIL format_%0d: lt=%0d addr=%0d wd=%h rw=%b, required %h rw=1",
                         i, lts[i], ads[i], mif.WriteData, mif.RegWrite, exp[i]);
            end
        end
    endtask

    task automatic test_zero_reg();
        logic [31:0] c0;
        drive(1, 1, 0, 3'd0, 2'd0, 32'd0, 32'hA5A5_0001, 5'd0);
        tick();
        c0 = m_cnt;
        checks++;
        if (mif.RegWrite !== 1'b0 || mif.WbValid !== 1'b1) begin
            errs++;
            $display("FAIL zero_reg: rw=%b v=%b, required 0/1", mif.RegWrite, mif.WbValid);
        end
        drive(0, 0, 0, 3'd0, 2'd0, 32'd0, 32'd0, 5'd1);
        tick();
        checks++;
        if (mif.RetireCount !== c0 + 32'd1) begin
            errs++;
            $display("FAIL zero_reg_count: cnt=%0d, required %0d", mif.RetireCount, c0 + 32'd1);
        end
    endtask

    task automatic test_stall_flush();
        drive(1, 1, 0, 3'd0, 2'd0, 32'd0, 32'h0BAD_F00D, 5'd12);
        tick();
        mif.Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1, 1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom));
            tick();
            checks++;
            if (mif.WriteData !== 32'h0BAD_F00D || mif.WriteRegister !== 5'd12 || mif.RegWrite !== 1'b1
                || mif.WbValid !== 1'b1 || mif.RetireCount !== m_cnt) begin
                errs++;
                $display("FAIL stall_hold_%0d: wd=%h wr=%0d rw=%b v=%b cnt=%0d, required 0badf00d/12/1/1/%0d",
                         i, mif.WriteData, mif.WriteRegister, mif.RegWrite, mif.WbValid, mif.RetireCount, m_cnt);
            end
        end
        mif.Flush = 1'b1;
        tick();
        checks++;
        if (mif.WbValid !== 1'b1 || mif.RegWrite !== 1'b1 || mif.WriteData !== 32'h0BAD_F00D) begin
            errs++;
            $display("FAIL stall_flush: v=%b rw=%b wd=%h, required 1/1/0badf00d",
                     mif.WbValid, mif.RegWrite, mif.WriteData);
        end
        mif.Stall = 1'b0;
        drive(1, 1, 0, 3'd0, 2'd0, 32'd0, 32'h1111_2222, 5'd3);
        tick();
        checks++;
        if (mif.WbValid !== 1'b0 || mif.RegWrite !== 1'b0 || mif.RetireCount !== m_cnt) begin
            errs++;
            $display("FAIL flush_bubble: v=%b rw=%b cnt=%0d, required 0/0/%0d",
                     mif.WbValid, mif.RegWrite, mif.RetireCount, m_cnt);
        end
        mif.Flush = 1'b0;
    endtask

    task automatic test_wrap_and_async_reset();
        logic [31:0] exp [3] = '{WRAP_BASE, 32'hFFFF_FFFF, 32'h0000_0000};
        Reset_n = 1'b0; #2; Reset_n = 1'b1;
        model_reset();
        drive(1, 1, 0, 3'd0, 2'd0, 32'd0, 32'h7777_0000, 5'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (wif.RetireCount !== exp[i]) begin
                errs++;
                $display("FAIL wrap_%0d: cnt=%h, required %h", i, wif.RetireCount, exp[i]);
            end
        end
        mif.Stall = 1'b1;
        tick();
        #2;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({mif.RegWrite, mif.WbValid, mif.Trap} !== 3'b000 || mif.WriteData !== 32'd0
            || mif.WriteRegister !== 5'd0 || mif.RetireCount !== 32'd0 || wif.RetireCount !== WRAP_BASE) begin
            errs++;
            $display("FAIL async_reset: rw=%b v=%b wd=%h wr=%0d cnt=%h/%h, required zeros and %h",
                     mif.RegWrite, mif.WbValid, mif.WriteData, mif.WriteRegister,
                     mif.RetireCount, wif.RetireCount, WRAP_BASE);
        end
        @(posedge Clock); #1;
        Reset_n = 1'b1;
        mif.Stall = 1'b0;
        model_reset();
    endtask

    task automatic test_misalign();
        drive(1, 1, 1, 3'd0, 2'd2, 32'hCAFE_BABE, 32'd0, 5'd7);
        tick();
        checks++;
        if (mif.RegWrite !== !TRAP_EN || mif.Trap !== TRAP_EN
            || (!TRAP_EN && mif.WriteData !== 32'hCAFE_BABE)) begin
            errs++;
            $display("FAIL misalign_lw: rw=%b trap=%b wd=%h, required rw=%b trap=%b",
                     mif.RegWrite, mif.Trap, mif.WriteData, !TRAP_EN, TRAP_EN);
        end
        drive(1, 1, 1, 3'd0, 2'd0, 32'h0101_0202, 32'd0, 5'd8);
        tick();
        drive(1, 1, 1, 3'd4, 2'd3, 32'h0101_0202, 32'd0, 5'd8);
        tick();
        checks++;
        if (mif.RegWrite !== 1'b1 || mif.Trap !== TRAP_EN || mif.WriteData !== 32'h0000_0002) begin
            errs++;
            $display("FAIL misalign_sticky: rw=%b trap=%b wd=%h, required 1/%b/00000002",
                     mif.RegWrite, mif.Trap, mif.WriteData, TRAP_EN);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            mif.Stall = ($urandom_range(0, 4) == 0);
            mif.Flush = ($urandom_range(0, 5) == 0);
            drive(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)),
                  2'($urandom), $urandom, $urandom, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom));
            tick();
            checks++;
            if (mif.WbValid !== m_valid || mif.RegWrite !== m_rw || mif.WriteRegister !== m_wr
                || (m_wd_known && mif.WriteData !== m_wd) || mif.RetireCount !== m_cnt
                || mif.Trap !== m_trap || wif.RetireCount !== WRAP_BASE + m_cnt) begin
                errs++;
                $display("FAIL random_%0d: v=%b rw=%b wr=%0d wd=%h cnt=%0d trap=%b wcnt=%h, required %b %b %0d %h %0d %b %h",
                         i, mif.WbValid, mif.RegWrite, mif.WriteRegister, mif.WriteData, mif.RetireCount,
                         mif.Trap, wif.RetireCount, m_valid, m_rw, m_wr, m_wd, m_cnt, m_trap, WRAP_BASE + m_cnt);
            end
        end
        mif.Stall = 1'b0;
        mif.Flush = 1'b0;
    endtask

    initial begin
        errs = 0;
        checks = 0;
        model_reset();
        test_reset();
        test_alu();
        test_format();
        test_zero_reg();
        test_stall_flush();
        test_wrap_and_async_reset();
        test_misalign();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
# writeback_stage

MEM/WB pipeline register and writeback formatter for the MIPS datapath. Captures one retiring instruction per cycle from the memory stage and selects ALU result or load data. Sign- or zero-extends sub-word loads and drives the register file's `RegWrite`, `WriteRegister` and `WriteData` inputs from registered state. Also supports stall, flush, `$zero` write suppression and a retired-instruction counter.

## Interface
- `RESET_PC_COUNT`, default 0: reset value of `RetireCount`.
- `Clock` input 1: rising-edge clock for all state.
- `Reset_n` input 1: asynchronous, active-low reset.
- `Stall` input 1: hold all WB state; no capture.
- `Flush` input 1: invalidate instruction being captured this edge.
- `MemValid` input 1: memory-stage slot holds a real instruction.
- `MemRegWrite` input 1: instruction writes a GPR.
- `MemToReg` input 1: 1 = load data, 0 = ALU result.
- `MemLoadType` input 3: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; 101–111 treated as LW.
- `MemAddrLow` input 2: byte address bits [1:0] of the load.
- `MemReadData` input 32: raw big-endian data-memory word.
- `MemAluResult` input 32: ALU result.
- `MemWriteRegister` input 5: destination GPR.
- `RegWrite` output 1: write enable to register file.
- `WriteRegister` output 5: destination to register file.
- `WriteData` output 32: formatted writeback value.
- `WbValid` output 1: WB slot holds a real instruction.
- `RetireCount` output 32: count of retired valid instructions.
- `Trap` output 1: sticky misaligned-load flag (only with `WB_MISALIGN_TRAP_EN`; otherwise tied 0).

## Operation
- **Capture:** on each rising `Clock` with `Stall`=0, the WB register loads the following from the Mem* inputs:
  - `WbValid` ← `MemValid & ~Flush`.
  - `RegWrite` ← `MemValid & ~Flush & MemRegWrite & (MemWriteRegister != 0)`.
  - `WriteRegister` ← `MemWriteRegister`.
  - `WriteData` ← formatted value.
- **Formatting:**
  - `MemToReg`=0: `MemAluResult` unchanged.
  - LW: `MemReadData`.
  - LH/LHU: halfword `MemReadData[31:16]` if `MemAddrLow[1]`=0, else `[15:0]`; sign-extended (LH) or zero-extended (LHU).
  - LB/LBU: byte `MemAddrLow`=0→`[31:24]`, 1→`[23:16]`, 2→`[15:8]`, 3→`[7:0]`; sign- or zero-extended.
  - LH ignores `MemAddrLow[0]`; LW ignores `MemAddrLow` entirely.
- **`$zero`:** a write to register 0 is captured with `RegWrite`=0; `WbValid` still follows `MemValid`.
- **Stall:** all WB registers, `RetireCount` and `Trap` hold. Outputs remain stable, so a held `RegWrite`=1 rewrites the same value (idempotent).
- **Flush:** with `Stall`=0, the captured slot becomes a bubble (`WbValid`=0, `RegWrite`=0). `WriteRegister`/`WriteData` may load but are don't-care.
- **Stall and Flush together:** Stall wins; nothing changes. Flush is not remembered.
- **RetireCount:** increments by 1 on each edge where the WB slot is advanced (`Stall`=0) and the outgoing `WbValid`=1. Wraps 0xFFFFFFFF→0.
- **Reset** (asynchronous, any time, including mid-stall):
  - `RegWrite`=0, `WriteRegister`=0, `WriteData`=0, `WbValid`=0, `Trap`=0.
  - `RetireCount`=`RESET_PC_COUNT`.
  - Takes effect without a clock edge; the first capture is on the first rising edge after `Reset_n` deasserts.

## Timing
- Latency: one cycle, Mem* inputs at edge N → outputs valid after edge N.
- The register file samples the outputs during cycle N+1.
- Throughput: one instruction per unstalled cycle.
- All outputs are registered; no combinational path from any input to any output.
- `Stall` and `Flush` are sampled at the rising edge only.

## Configuration
- **`WB_MISALIGN_TRAP_EN` defined:**
  - A load is misaligned if it is LW/default with `MemAddrLow`≠0, or LH/LHU with `MemAddrLow[0]`=1.
  - A valid, unflushed, unstalled misaligned load captures `RegWrite`=0 and sets `Trap`=1.
  - `Trap` stays 1 until reset. `WbValid` and `RetireCount` behave normally.
- **`WB_MISALIGN_TRAP_EN` undefined:**
  - No detection; `Trap` is constant 0.
  - Misaligned loads are formatted per the address-bit rules above and written normally.

## Test plan
- Reset with all inputs active → all outputs 0, `RetireCount`=`RESET_PC_COUNT`; deassert, then MemValid=1, MemRegWrite=1, MemToReg=0, MemAluResult=0x12345678, MemWriteRegister=5 → next cycle `RegWrite`=1, `WriteRegister`=5, `WriteData`=0x12345678, `RetireCount` increments on following edge.
- MemReadData=0x80F17F01, MemToReg=1: LB addr 0 → 0xFFFFFF80; LBU addr 1 → 0x000000F1; LH addr 2 → 0x00007F01; LHU addr 0 → 0x000080F1; LW → 0x80F17F01.
- MemWriteRegister=0, MemRegWrite=1, MemValid=1 → `RegWrite`=0, `WbValid`=1, `RetireCount` still increments.
- Stall=1 for 3 cycles with changing Mem* inputs → outputs and `RetireCount` frozen; Stall=1 with Flush=1 → no change; Flush=1 alone → `WbValid`=0, `RegWrite`=0.
- Force `RetireCount` to wrap from `RESET_PC_COUNT`=0xFFFFFFFE over two valid retirements → 0xFFFFFFFF then 0x00000000; assert `Reset_n` low mid-stall between clock edges → outputs clear immediately.
- With `WB_MISALIGN_TRAP_EN`: LW at MemAddrLow=2 → `RegWrite`=0, `Trap`=1 and stays 1 through later aligned loads. Without it: same stimulus → `RegWrite`=1, `WriteData`=MemReadData, `Trap`=0.
